// File: rtl/dest_reg_tracker.sv
// Destination-register select, in-flight write tracker and RAW hazard detection for decode.
// Optional macro DEST_FWD_EN adds forwarding stage selects and restricts stalls to load-use.

module dest_reg_tracker_chk #(
  parameter int DEPTH = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             id_valid,
  input logic             memread,
  input logic             advance,
  input logic             stall_req,
  input logic [DEPTH-1:0] v_q,
  input logic [DEPTH-1:0] ld_q
);

  a_stall_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    stall_req |-> id_valid);

  a_ld_capture: assert property (@(posedge clk) disable iff (!rst_n)
    advance |=> (ld_q[0] == $past(memread)));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !advance |=> ((v_q == $past(v_q)) && (ld_q == $past(ld_q))));

  generate
    if (DEPTH > 1) begin : g_shift
      a_shift: assert property (@(posedge clk) disable iff (!rst_n)
        advance |=> ((v_q[DEPTH-1:1] == $past(v_q[DEPTH-2:0])) &&
                     (ld_q[DEPTH-1:1] == $past(ld_q[DEPTH-2:0]))));
    end
  endgenerate

endmodule

module dest_reg_tracker #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  input  logic          regdst,
  input  logic          mf,
  input  logic          regdst_jal,
  input  logic          regwrite,
  input  logic          memread,
  input  logic [AW-1:0] rs_src,
  input  logic [AW-1:0] rt_src,
  input  logic          rs_used,
  input  logic          rt_used,
  input  logic          advance,
  input  logic          flush,
  output logic [AW-1:0] dest,
  output logic          haz_rs,
  output logic          haz_rt,
  output logic          stall_req,
  output logic          wb_valid,
  output logic [AW-1:0] wb_dest
`ifdef DEST_FWD_EN
  ,
  output logic [3:0]    fwd_rs_sel,
  output logic [3:0]    fwd_rt_sel
`endif
);

  localparam logic [AW-1:0] ZERO_REG = {AW{1'b0}};
  localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [AW-1:0]    d_q [DEPTH];
  logic [AW-1:0]    d_d [DEPTH];
  logic [DEPTH-1:0] match_rs_s, match_rt_s;
  logic             load_v_s;

  // Destination select: mf beats the jal link, which beats regdst.
  always_comb begin
    if (mf) begin
      dest = rt;
    end else if (regdst_jal) begin
      dest = LINK_IDX;
    end else if (!regdst) begin
      dest = rt;
    end else begin
      dest = rd;
    end
  end

  // Per-entry source compare; r0 and unread sources never match.
  always_comb begin
    match_rs_s = {DEPTH{1'b0}};
    match_rt_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      match_rs_s[k] = rs_used && (rs_src != ZERO_REG) && v_q[k] && (d_q[k] == rs_src);
      match_rt_s[k] = rt_used && (rt_src != ZERO_REG) && v_q[k] && (d_q[k] == rt_src);
    end
  end

  assign haz_rs = |match_rs_s;
  assign haz_rt = |match_rt_s;

`ifdef DEST_FWD_EN
  logic [3:0] rs_idx_s, rt_idx_s;
  logic       load_use_s;

  // Youngest-match search: scan oldest to youngest so the lowest index wins.
  always_comb begin
    rs_idx_s = 4'd0;
    rt_idx_s = 4'd0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_rs_s[k]) begin
        rs_idx_s = 4'(k);
      end else begin
        rs_idx_s = rs_idx_s;
      end
      if (match_rt_s[k]) begin
        rt_idx_s = 4'(k);
      end else begin
        rt_idx_s = rt_idx_s;
      end
    end
  end

  assign fwd_rs_sel = haz_rs ? (rs_idx_s + 4'd1) : 4'd0;
  assign fwd_rt_sel = haz_rt ? (rt_idx_s + 4'd1) : 4'd0;

  // A load still sitting in E[0] has no data yet; everything older can be forwarded.
  assign load_use_s = ld_q[0] && ((haz_rs && (rs_idx_s == 4'd0)) ||
                                  (haz_rt && (rt_idx_s == 4'd0)));
  assign stall_req  = id_valid && load_use_s;
`else
  assign stall_req  = id_valid && (haz_rs || haz_rt);
`endif

  // A stalled or flushed slot enters the tracker as a bubble.
  assign load_v_s = id_valid && regwrite && !flush && !stall_req && (dest != ZERO_REG);

  // Next state: shift one stage on advance, otherwise hold everything.
  always_comb begin
    v_d  = v_q;
    ld_d = ld_q;
    d_d  = d_q;
    if (advance) begin
      for (int k = 1; k < DEPTH; k++) begin
        v_d[k]  = v_q[k-1];
        ld_d[k] = ld_q[k-1];
        d_d[k]  = d_q[k-1];
      end
      v_d[0]  = load_v_s;
      ld_d[0] = memread;
      d_d[0]  = dest;
    end else begin
      v_d  = v_q;
      ld_d = ld_q;
      d_d  = d_q;
    end
  end

  // Tracker state; reset drops every in-flight entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= {DEPTH{1'b0}};
      ld_q <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= ZERO_REG;
      end
    end else begin
      v_q  <= v_d;
      ld_q <= ld_d;
      d_q  <= d_d;
    end
  end

  assign wb_valid = v_q[DEPTH-1];
  assign wb_dest  = d_q[DEPTH-1];

  dest_reg_tracker_chk #(.DEPTH(DEPTH)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .memread   (memread),
    .advance   (advance),
    .stall_req (stall_req),
    .v_q       (v_q),
    .ld_q      (ld_q)
  );

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Self-checking bench for dest_reg_tracker: directed scenarios plus a random run against a
// queue-based scoreboard of in-flight writes (front = oldest, back = youngest).

module tb_dest_reg_tracker;

  localparam int AW    = 5;
  localparam int DEPTH = 3;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] d;
    logic          ld;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, regdst, mf, regdst_jal, regwrite, memread;
  logic          rs_used, rt_used, advance, flush;
  logic [AW-1:0] rt, rd, rs_src, rt_src;
  logic [AW-1:0] dest, wb_dest;
  logic          haz_rs, haz_rt, stall_req, wb_valid;
`ifdef DEST_FWD_EN
  logic [3:0]    fwd_rs_sel, fwd_rt_sel;
`endif

  ent_t pipe_q[$];
  int   checks   = 0;
  int   failures = 0;

  dest_reg_tracker #(.AW(AW), .DEPTH(DEPTH), .LINK_REG(31)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .rt         (rt),
    .rd         (rd),
    .regdst     (regdst),
    .mf         (mf),
    .regdst_jal (regdst_jal),
    .regwrite   (regwrite),
    .memread    (memread),
    .rs_src     (rs_src),
    .rt_src     (rt_src),
    .rs_used    (rs_used),
    .rt_used    (rt_used),
    .advance    (advance),
    .flush      (flush),
    .dest       (dest),
    .haz_rs     (haz_rs),
    .haz_rt     (haz_rt),
    .stall_req  (stall_req),
    .wb_valid   (wb_valid),
    .wb_dest    (wb_dest)
`ifdef DEST_FWD_EN
    ,
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] m_dest();
    if (mf) return rt;
    else if (regdst_jal) return 5'd31;
    else if (!regdst) return rt;
    else return rd;
  endfunction

  // Youngest matching age (0 = E[0]) or -1.
  function automatic int m_match(logic [AW-1:0] src, logic used);
    if (!used || src == 5'd0) return -1;
    for (int k = 0; k < DEPTH; k++)
      if (pipe_q[DEPTH-1-k].v && pipe_q[DEPTH-1-k].d == src) return k;
    return -1;
  endfunction

  function automatic logic m_stall();
    int ks = m_match(rs_src, rs_used);
    int kt = m_match(rt_src, rt_used);
`ifdef DEST_FWD_EN
    return id_valid && pipe_q[DEPTH-1].ld && (ks == 0 || kt == 0);
`else
    return id_valid && (ks >= 0 || kt >= 0);
`endif
  endfunction

  task automatic reset_model();
    pipe_q.delete();
    for (int k = 0; k < DEPTH; k++) pipe_q.push_back(ent_t'(0));
  endtask

  task automatic idle();
    id_valid = 1'b0; regwrite = 1'b0; memread = 1'b0; mf = 1'b0; regdst = 1'b0;
    regdst_jal = 1'b0; rt = 5'd0; rd = 5'd0; rs_src = 5'd0; rt_src = 5'd0;
    rs_used = 1'b0; rt_used = 1'b0; flush = 1'b0; advance = 1'b1;
  endtask

  task automatic issue(input logic [AW-1:0] d, input logic ld);
    idle();
    id_valid = 1'b1; regwrite = 1'b1; memread = ld;
    regdst = ~ld; rd = d; rt = d;
  endtask

  // Push the decoding slot into the scoreboard on an advancing edge; retire the oldest.
  task automatic tick();
    ent_t e;
    logic adv;
    e.v  = id_valid && regwrite && !flush && !m_stall() && (m_dest() != 5'd0);
    e.d  = m_dest();
    e.ld = memread;
    adv  = advance;
    @(posedge clk);
    if (adv && rst_n === 1'b1) begin
      void'(pipe_q.pop_front());
      pipe_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    id_valid = 1'b1; rs_used = 1'b1; rs_src = 5'd5; rt_used = 1'b1; rt_src = 5'd5;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (haz_rs !== 1'b0) begin failures++; $display("FAIL reset_haz_rs got=%b exp=0", haz_rs); end
    checks++; if (haz_rt !== 1'b0) begin failures++; $display("FAIL reset_haz_rt got=%b exp=0", haz_rt); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
`ifdef DEST_FWD_EN
    checks++; if (fwd_rs_sel !== 4'd0 || fwd_rt_sel !== 4'd0) begin failures++;
      $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fwd_rs_sel, fwd_rt_sel); end
`endif
    rst_n = 1'b1;
    reset_model();
    idle();
    tick();
    #1;
    checks++; if (wb_valid !== 1'b0 || haz_rs !== 1'b0) begin failures++;
      $display("FAIL post_reset got wb=%b haz=%b exp=0/0", wb_valid, haz_rs); end
  endtask

  task automatic test_dest_select();
    idle();
    mf = 1'b1; regdst_jal = 1'b1; rt = 5'd7; rd = 5'd12; regdst = 1'b1;
    #1; checks++; if (dest !== 5'd7) begin failures++; $display("FAIL dest_mf got=%0d exp=7", dest); end
    mf = 1'b0;
    #1; checks++; if (dest !== 5'd31) begin failures++; $display("FAIL dest_jal got=%0d exp=31", dest); end
    regdst_jal = 1'b0;
    #1; checks++; if (dest !== 5'd12) begin failures++; $display("FAIL dest_rd got=%0d exp=12", dest); end
    regdst = 1'b0;
    #1; checks++; if (dest !== 5'd7) begin failures++; $display("FAIL dest_rt got=%0d exp=7", dest); end
    idle();
  endtask

  task automatic test_retire();
    logic exp_v;
    do_reset();
    issue(5'd5, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      idle();
      #1;
      exp_v = (e == 3);
      checks++; if (wb_valid !== exp_v) begin failures++;
        $display("FAIL retire_wb_valid edge=%0d got=%b exp=%b", e, wb_valid, exp_v); end
      if (exp_v) begin
        checks++; if (wb_dest !== 5'd5) begin failures++;
          $display("FAIL retire_wb_dest got=%0d exp=5", wb_dest); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
`ifdef DEST_FWD_EN
    localparam int EXP_STALLS = 0;
`else
    localparam int EXP_STALLS = 3;
`endif
    do_reset();
    issue(5'd5, 1'b0);
    tick();
    issue(5'd6, 1'b0);
    rs_used = 1'b1; rs_src = 5'd5; rt_used = 1'b1; rt_src = 5'd6;
    #1;
    checks++; if (haz_rs !== 1'b1) begin failures++; $display("FAIL b2b_haz_rs got=%b exp=1", haz_rs); end
    checks++; if (stall_req !== (EXP_STALLS != 0)) begin failures++;
      $display("FAIL b2b_stall got=%b exp=%b", stall_req, EXP_STALLS != 0); end
    stalls = 0;
    while (stall_req === 1'b1 && stalls < 8) begin
      checks++; if (haz_rt !== 1'b0) begin failures++;
        $display("FAIL b2b_bubble got haz_rt=%b exp=0", haz_rt); end
      stalls++;
      tick();
      #1;
    end
    checks++; if (stalls !== EXP_STALLS) begin failures++;
      $display("FAIL b2b_stall_cycles got=%0d exp=%0d", stalls, EXP_STALLS); end
`ifndef DEST_FWD_EN
    checks++; if (haz_rs !== 1'b0) begin failures++; $display("FAIL b2b_cleared got=%b exp=0", haz_rs); end
`endif
    tick();
    idle();
    rs_used = 1'b1; rs_src = 5'd6;
    #1;
    checks++; if (haz_rs !== 1'b1) begin failures++; $display("FAIL b2b_reader_tracked got=%b exp=1", haz_rs); end
  endtask

  task automatic test_boundaries();
    logic any_wb;
    do_reset();
    issue(5'd0, 1'b0);
    tick();
    issue(5'd7, 1'b0); regwrite = 1'b0;
    tick();
    issue(5'd8, 1'b0); flush = 1'b1;
    tick();
    idle();
    rs_used = 1'b1; rs_src = 5'd0; rt_used = 1'b1; rt_src = 5'd7;
    #1;
    checks++; if (haz_rs !== 1'b0 || haz_rt !== 1'b0) begin failures++;
      $display("FAIL r0_nowrite_haz got=%b/%b exp=0/0", haz_rs, haz_rt); end
    rt_src = 5'd8;
    #1;
    checks++; if (haz_rt !== 1'b0) begin failures++; $display("FAIL flush_haz got=%b exp=0", haz_rt); end
    any_wb = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      any_wb = any_wb | wb_valid;
    end
    checks++; if (any_wb !== 1'b0) begin failures++; $display("FAIL untracked_retire got=%b exp=0", any_wb); end

    do_reset();
    issue(5'd10, 1'b0);
    tick();
    issue(5'd11, 1'b0);
    advance = 1'b0;
    rt_used = 1'b1; rt_src = 5'd10; rs_used = 1'b1; rs_src = 5'd11;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      checks++; if (haz_rt !== 1'b1 || haz_rs !== 1'b0 || wb_valid !== 1'b0) begin failures++;
        $display("FAIL hold_cycle%0d got rt=%b rs=%b wb=%b exp=1/0/0", c, haz_rt, haz_rs, wb_valid); end
    end
    idle();
    tick();
    tick();
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_dest !== 5'd10) begin failures++;
      $display("FAIL hold_release got wb=%b dest=%0d exp=1/10", wb_valid, wb_dest); end

    do_reset();
    issue(5'd12, 1'b0);
    tick();
    issue(5'd13, 1'b0);
    tick();
    idle();
    id_valid = 1'b1; rs_used = 1'b1; rs_src = 5'd12;
    #1;
    checks++; if (haz_rs !== 1'b1) begin failures++; $display("FAIL premid_haz got=%b exp=1", haz_rs); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (haz_rs !== 1'b0 || stall_req !== 1'b0 || wb_valid !== 1'b0) begin failures++;
      $display("FAIL midreset got haz=%b stall=%b wb=%b exp=0/0/0", haz_rs, stall_req, wb_valid); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL midreset_retire got=%b exp=0", wb_valid); end
    rst_n = 1'b1;
    reset_model();
    idle();
  endtask

`ifdef DEST_FWD_EN
  task automatic test_fwd();
    do_reset();
    issue(5'd9, 1'b1);
    tick();
    idle();
    id_valid = 1'b1; rt_used = 1'b1; rt_src = 5'd9;
    #1;
    checks++; if (stall_req !== 1'b1 || fwd_rt_sel !== 4'd1) begin failures++;
      $display("FAIL fwd_load_use got stall=%b sel=%0d exp=1/1", stall_req, fwd_rt_sel); end
    tick();
    #1;
    checks++; if (stall_req !== 1'b0 || fwd_rt_sel !== 4'd2) begin failures++;
      $display("FAIL fwd_after_bubble got stall=%b sel=%0d exp=0/2", stall_req, fwd_rt_sel); end

    do_reset();
    issue(5'd9, 1'b0); tick();
    issue(5'd1, 1'b0); tick();
    issue(5'd9, 1'b0); tick();
    idle();
    id_valid = 1'b1; rt_used = 1'b1; rt_src = 5'd9; rs_used = 1'b1; rs_src = 5'd1;
    #1;
    checks++; if (fwd_rt_sel !== 4'd1 || fwd_rs_sel !== 4'd2 || stall_req !== 1'b0) begin failures++;
      $display("FAIL fwd_youngest got rt=%0d rs=%0d stall=%b exp=1/2/0", fwd_rt_sel, fwd_rs_sel, stall_req); end
  endtask
`endif

  task automatic test_random();
    int ks, kt;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      regwrite   = ($urandom_range(0, 3) != 0);
      memread    = ($urandom_range(0, 2) == 0);
      mf         = ($urandom_range(0, 7) == 0);
      regdst_jal = ($urandom_range(0, 7) == 0);
      regdst     = ($urandom_range(0, 1) == 1);
      rt         = 5'($urandom_range(0, 7));
      rd         = 5'($urandom_range(0, 7));
      rs_src     = 5'($urandom_range(0, 7));
      rt_src     = 5'($urandom_range(0, 7));
      rs_used    = ($urandom_range(0, 3) != 0);
      rt_used    = ($urandom_range(0, 3) != 0);
      advance    = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 7) == 0);
      #1;
      ks = m_match(rs_src, rs_used);
      kt = m_match(rt_src, rt_used);
      checks++; if (dest !== m_dest()) begin failures++;
        $display("FAIL rnd_dest cyc=%0d got=%0d exp=%0d", c, dest, m_dest()); end
      checks++; if (haz_rs !== (ks >= 0) || haz_rt !== (kt >= 0)) begin failures++;
        $display("FAIL rnd_haz cyc=%0d got=%b/%b exp=%b/%b", c, haz_rs, haz_rt, ks >= 0, kt >= 0); end
      checks++; if (stall_req !== m_stall()) begin failures++;
        $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall_req, m_stall()); end
      checks++; if (wb_valid !== pipe_q[0].v) begin failures++;
        $display("FAIL rnd_wb_valid cyc=%0d got=%b exp=%b", c, wb_valid, pipe_q[0].v); end
      if (pipe_q[0].v) begin
        checks++; if (wb_dest !== pipe_q[0].d) begin failures++;
          $display("FAIL rnd_wb_dest cyc=%0d got=%0d exp=%0d", c, wb_dest, pipe_q[0].d); end
      end
`ifdef DEST_FWD_EN
      checks++; if (fwd_rs_sel !== ((ks < 0) ? 4'd0 : 4'(ks + 1)) ||
                    fwd_rt_sel !== ((kt < 0) ? 4'd0 : 4'(kt + 1))) begin failures++;
        $display("FAIL rnd_fwd cyc=%0d got=%0d/%0d exp=%0d/%0d", c, fwd_rs_sel, fwd_rt_sel, ks + 1, kt + 1); end
`endif
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    reset_model();
    test_reset();
    test_dest_select();
    test_retire();
    test_back_to_back();
    test_boundaries();
`ifdef DEST_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dest_reg_tracker.md
DEST_REG_TRACKER -- requirements
Module: dest_reg_tracker

Interface
REQ-001 SHALL have parameter AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, meaning in-flight tracker stages (legal 1..8).
REQ-003 SHALL have parameter LINK_REG, default 31, meaning the jal link-register index.
REQ-004 SHALL have ports, in order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- rt, rd  in  AW  decoded register fields.
- regdst, mf, regdst_jal  in  1  destination-select controls.
- regwrite  in  1  instruction writes the register file.
- memread  in  1  instruction is a load.
- rs_src, rt_src  in  AW  source registers of the decoding instruction.
- rs_used, rt_used  in  1  the corresponding source is read.
- advance  in  1  pipeline moves one stage this cycle.
- flush  in  1  squash the decoding instruction.
- dest  out  AW  combinational selected destination.
- haz_rs, haz_rt  out  1  source matches an in-flight destination.
- stall_req  out  1  decode must hold.
- wb_valid  out  1  oldest entry is a valid write.
- wb_dest  out  AW  destination of the oldest entry.
- fwd_rs_sel, fwd_rt_sel  out  4  forwarding stage select; present only under DEST_FWD_EN.

Function
REQ-005 dest SHALL be rt when mf=1; else LINK_REG when regdst_jal=1; else rt when regdst=0; else rd.
REQ-006 Tracker SHALL be DEPTH entries E[0..DEPTH-1] of {v, d, ld}; E[0] is the youngest.
REQ-007 On a clk edge with advance=1, E[k] SHALL take E[k-1] for k>=1.
REQ-008 On a clk edge with advance=1, E[0] SHALL load {v=id_valid&regwrite&~flush&~stall_req&(dest!=0), d=dest, ld=memread}.
REQ-009 With advance=0, all entries SHALL hold, regardless of flush.
REQ-010 When v=0, the d and ld fields SHALL be don't-care and never used.
REQ-011 haz_rs SHALL be 1 iff rs_used=1, rs_src!=0 and some E[k].v=1 has E[k].d==rs_src.
REQ-012 haz_rt SHALL follow REQ-011 using rt_used and rt_src.
REQ-013 haz_rs, haz_rt and stall_req SHALL be combinational, with zero-cycle latency.
REQ-014 Hazard outputs SHALL NOT depend on id_valid.
REQ-015 stall_req SHALL be qualified by id_valid.
REQ-016 When several entries match, the youngest match (lowest k) SHALL be the reported source.
REQ-017 wb_valid/wb_dest SHALL equal E[DEPTH-1].v/E[DEPTH-1].d.
REQ-018 An entry retires as it shifts out of E[DEPTH-1]; there is no other retire path.
REQ-019 Register 0 SHALL never be tracked and SHALL never raise a hazard.
REQ-020 When flush=1 and stall_req=1 in the same cycle, a bubble SHALL be inserted and flush SHALL win.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear every E[k].v.
REQ-022 During and after reset, wb_valid, haz_rs, haz_rt and stall_req SHALL be 0.
REQ-023 During and after reset, fwd_rs_sel and fwd_rt_sel SHALL be 0.
REQ-024 Deassertion of rst_n SHALL take effect on the next clk edge.
REQ-025 Reset asserted mid-stall SHALL discard all in-flight entries, with no retire pulse.

Configuration
REQ-026 The macro DEST_FWD_EN SHALL select between stall-only and forwarding operation.
REQ-027 Without DEST_FWD_EN:
- stall_req = id_valid & (haz_rs|haz_rt).
- The fwd_*_sel ports SHALL be absent.
REQ-028 With DEST_FWD_EN, fwd_rs_sel SHALL be k+1 for the youngest matching entry, else 0.
REQ-029 With DEST_FWD_EN, fwd_rt_sel SHALL follow REQ-028 for the rt source.
REQ-030 With DEST_FWD_EN, stall_req SHALL be 1 only when id_valid=1 and the youngest match is E[0] with ld=1 (load-use).
REQ-031 With DEST_FWD_EN, a load match in E[k], k>=1, SHALL forward without stalling.

Verification
REQ-032 Select priority: mf=1, regdst_jal=1, rt=7 -> dest=7; mf=0, regdst_jal=1 -> dest=31; regdst=1, rd=12 -> dest=12.
REQ-033 Retire timing: write to r5, advance held high, DEPTH=3 -> wb_valid=1 with wb_dest=5 exactly 3 edges later, for one cycle.
REQ-034 Back-to-back hazard (no FWD): add r5, next instruction reads rs_src=5 -> haz_rs=1 and stall_req=1; a bubble enters E[0]; stall clears once r5 retires.
REQ-035 Forwarding (FWD), load into E[0]:
- lw r9 in E[0], reader rt_src=9 -> stall_req=1, fwd_rt_sel=1.
- After one bubble -> stall_req=0, fwd_rt_sel=2.
REQ-036 Forwarding (FWD), youngest match: r9 written in both E[0] (non-load) and E[2] -> fwd_rt_sel=1.
REQ-037 Boundaries:
- Write to r0, or regwrite=0 -> never tracked.
- flush=1 with advance=1 -> bubble inserted.
- advance=0 for 4 cycles -> outputs held.
- rst_n pulsed mid-pipeline -> all outputs 0 immediately.
